lpif_link_bringup_ctrl: RTL and testbench
=========================================

Name: lpif_link_bringup_ctrl

Overview:
- Sequences bring-up and tear-down of one LPIF-over-AIB logic link.
- Sits between the AIB PHY status and the `*_top` wrapper's `tx_online` / `rx_online` inputs, upstream of `ll_auto_sync`.
- Waits for PHY ready to settle, enables TX, waits for RX marker alignment, enables RX, then waits for the remote side to report ACTIVE on the downstream state field.
- Handles timeouts, link loss and error recovery, and keeps a saturating error counter.

Parameters:
- `CNT_W`, 16, width of the settle and timeout counters.
- `ACTIVE_STATE`, 4'h1, `dstrm_state` encoding that means the remote side is active.
- `ERRCNT_W`, 8, width of the saturating error counter.

Ports:
- `clk_wr`  in  1  link clock.
- `rst_wr_n`  in  1  reset; asynchronous assert, active-low.
- `link_en`  in  1  software enable for the link.
- `phy_ready`  in  1  AIB transfer enable, both directions.
- `rx_align_done`  in  1  RX marker/strobe alignment achieved.
- `dstrm_valid`  in  1  downstream beat valid.
- `dstrm_state`  in  4  remote LPIF state.
- `settle_value`  in  CNT_W  number of consecutive `phy_ready` cycles required.
- `timeout_value`  in  CNT_W  per-phase timeout; 0 disables timeouts.
- `err_clr`  in  1  clears the sticky error and leaves ERROR.
- `tx_online`  out  1  drives the wrapper's `tx_online`.
- `rx_online`  out  1  drives the wrapper's `rx_online`.
- `link_up`  out  1  link is ACTIVE.
- `link_err`  out  1  sticky error flag.
- `err_count`  out  ERRCNT_W  saturating count of entries into ERROR.
- `fsm_state`  out  3  current state encoding, for debug.

Behaviour:
- Single clock domain `clk_wr`. Reset is asynchronous, active-low, on `rst_wr_n`. All outputs are registered.
- Reset values:
  - state = IDLE (3'd0).
  - `tx_online`, `rx_online`, `link_up`, `link_err` = 0.
  - `err_count` = 0.
  - settle counter and timeout counter = 0.
- State encodings: IDLE=0, WAIT_PHY=1, TX_ON=2, RX_ON=3, ACTIVE=4, ERROR=5. Encodings 6 and 7 are illegal and return to IDLE on the next clock.
- IDLE:
  - All outputs off except `link_err` and `err_count`.
  - Go to WAIT_PHY when `link_en` = 1.
- WAIT_PHY:
  - Settle counter increments while `phy_ready` = 1 and clears to 0 when `phy_ready` = 0.
  - When the counter equals `settle_value`, go to TX_ON and set `tx_online` = 1 in the same edge.
  - `settle_value` = 0 means TX_ON is entered on the first cycle `phy_ready` = 1.
- TX_ON:
  - `tx_online` = 1.
  - `rx_align_done` = 1 → go to RX_ON and set `rx_online` = 1.
- RX_ON:
  - `tx_online` = 1 and `rx_online` = 1.
  - `dstrm_valid` = 1 and `dstrm_state` = `ACTIVE_STATE` in the same cycle → go to ACTIVE and set `link_up` = 1.
- ACTIVE:
  - `tx_online`, `rx_online` and `link_up` are all 1.
  - `rx_align_done` = 0 → go to ERROR.
- Timeout:
  - The timeout counter clears on every state change.
  - It increments each cycle in TX_ON and RX_ON.
  - When `timeout_value` != 0 and the counter reaches `timeout_value`, go to ERROR.
  - Counters saturate; they never wrap.
- ERROR:
  - On entry: `link_err` = 1 and `err_count` += 1, saturating at all-ones.
  - `tx_online`, `rx_online` and `link_up` = 0.
  - Stay in ERROR until `err_clr` = 1, then go to IDLE and clear `link_err`.
  - `link_en` is ignored while in ERROR.
- Transition priority each cycle, highest first:
  1. `link_en` = 0 in WAIT_PHY, TX_ON, RX_ON or ACTIVE → IDLE. This is a clean tear-down: no error, all onlines drop on the next edge.
  2. `phy_ready` = 0 in TX_ON, RX_ON or ACTIVE → ERROR.
  3. Timeout.
  4. Forward progress.
- `err_clr` asserted outside ERROR: no effect.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous), including `err_count`.
- Latency: each input event takes effect on the outputs one clock after it is sampled.

Decomposition:
- Shared package `lpif_ctrl_pkg`:
  - `typedef enum logic [2:0]` for the FSM states.
  - Default `ACTIVE_STATE` constant.
- One sub-module: `lpif_sat_counter`, a parameterised saturating counter with clear and increment inputs.
  - Instantiated for the settle counter, the timeout counter and `err_count`.

Test Plan:
- Normal bring-up: `settle_value`=4, `link_en`=1, `phy_ready`=1 held.
  - `tx_online` rises 6 cycles after `link_en` (1 cycle to WAIT_PHY, 4 settle cycles, 1 registration cycle).
  - `rx_align_done`=1 → `rx_online`=1 one cycle later.
  - `dstrm_valid`=1 with `dstrm_state`=4'h1 → `link_up`=1 one cycle later; `fsm_state`=4.
- Settle glitch: `phy_ready` drops for 1 cycle after 3 good cycles, with `settle_value`=4.
  - Counter restarts; `tx_online` rises only after 4 further consecutive good cycles.
- Timeout: `timeout_value`=10, `rx_align_done` held 0 in TX_ON.
  - ERROR entered after 10 cycles; `link_err`=1, `err_count`=1, `tx_online`=0.
  - `err_clr` pulse → IDLE; `link_err`=0.
- Simultaneous events in ACTIVE: `link_en`=0 and `phy_ready`=0 in the same cycle.
  - Goes to IDLE, not ERROR; `link_err` stays 0; all onlines 0 the next cycle.
- Saturation: force 256 consecutive errors with `ERRCNT_W`=8 → `err_count` holds 8'hFF.
- Async reset asserted while ACTIVE: all outputs 0 without waiting for a clock edge; `err_count`=0.

Source files
------------

// File: rtl/lpif_ctrl_pkg.sv
// Shared types for LPIF-over-AIB link bring-up: FSM state encoding, the default
// remote-ACTIVE code and output decode helpers used by the controller.
package lpif_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PHY = 3'd1,
    ST_TX_ON    = 3'd2,
    ST_RX_ON    = 3'd3,
    ST_ACTIVE   = 3'd4,
    ST_ERROR    = 3'd5
  } link_state_e;

  localparam logic [3:0] LPIF_ACTIVE_STATE = 4'h1;

  function automatic logic tx_phase(input link_state_e s);
    return (s == ST_TX_ON) || (s == ST_RX_ON) || (s == ST_ACTIVE);
  endfunction

  function automatic logic rx_phase(input link_state_e s);
    return (s == ST_RX_ON) || (s == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/lpif_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// One-cycle latency from clr/inc to cnt; holds at all-ones instead of wrapping.
module lpif_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/lpif_link_bringup_ctrl.sv
// Bring-up / tear-down sequencer for one LPIF-over-AIB link: PHY settle, TX, RX align, remote ACTIVE.
// All outputs registered; every sampled input event shows on the outputs one clock later.
module lpif_link_bringup_ctrl
  import lpif_ctrl_pkg::*;
#(
  parameter int         CNT_W        = 16,
  parameter logic [3:0] ACTIVE_STATE = LPIF_ACTIVE_STATE,
  parameter int         ERRCNT_W     = 8
) (
  input  logic                clk_wr,
  input  logic                rst_wr_n,
  input  logic                link_en,
  input  logic                phy_ready,
  input  logic                rx_align_done,
  input  logic                dstrm_valid,
  input  logic [3:0]          dstrm_state,
  input  logic [CNT_W-1:0]    settle_value,
  input  logic [CNT_W-1:0]    timeout_value,
  input  logic                err_clr,
  output logic                tx_online,
  output logic                rx_online,
  output logic                link_up,
  output logic                link_err,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [2:0]          fsm_state
);

  link_state_e        state, state_nxt;
  logic [CNT_W-1:0]   settle_cnt, tmo_cnt;
  logic               settle_clr, settle_inc;
  logic               tmo_clr, tmo_inc, tmo_hit;
  logic               err_entry;
  logic               tx_nxt, rx_nxt, up_nxt, err_nxt;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // >= rather than == so a timeout lowered mid-phase still fires
  assign tmo_hit = (timeout_value != '0) && (tmo_cnt >= timeout_value);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (link_en) state_nxt = ST_WAIT_PHY;
      end
      ST_WAIT_PHY: begin
        if (!link_en)                                    state_nxt = ST_IDLE;
        else if (phy_ready && (settle_cnt == settle_value)) state_nxt = ST_TX_ON;
      end
      ST_TX_ON: begin
        if (!link_en)           state_nxt = ST_IDLE;
        else if (!phy_ready)    state_nxt = ST_ERROR;
        else if (tmo_hit)       state_nxt = ST_ERROR;
        else if (rx_align_done) state_nxt = ST_RX_ON;
      end
      ST_RX_ON: begin
        if (!link_en)        state_nxt = ST_IDLE;
        else if (!phy_ready) state_nxt = ST_ERROR;
        else if (tmo_hit)    state_nxt = ST_ERROR;
        else if (dstrm_valid && (dstrm_state == ACTIVE_STATE)) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!link_en)                        state_nxt = ST_IDLE;
        else if (!phy_ready || !rx_align_done) state_nxt = ST_ERROR;
      end
      ST_ERROR: begin
        if (err_clr) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    tx_nxt  = tx_phase(state_nxt);
    rx_nxt  = rx_phase(state_nxt);
    up_nxt  = (state_nxt == ST_ACTIVE);
    err_nxt = (state_nxt == ST_ERROR);
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      tx_online <= 1'b0;
      rx_online <= 1'b0;
      link_up   <= 1'b0;
      link_err  <= 1'b0;
    end else begin
      tx_online <= tx_nxt;
      rx_online <= rx_nxt;
      link_up   <= up_nxt;
      link_err  <= err_nxt;
    end
  end

  assign fsm_state = state;

  // Settle count is the run length of consecutive phy_ready cycles in WAIT_PHY
  assign settle_clr = (state != ST_WAIT_PHY) || !phy_ready;
  assign settle_inc = 1'b1;

  assign tmo_clr   = (state_nxt != state) || !((state == ST_TX_ON) || (state == ST_RX_ON));
  assign tmo_inc   = 1'b1;
  assign err_entry = (state_nxt == ST_ERROR) && (state != ST_ERROR);

  lpif_sat_counter #(.W(CNT_W)) u_settle_cnt (
    .clk   (clk_wr),
    .rst_n (rst_wr_n),
    .clr   (settle_clr),
    .inc   (settle_inc),
    .cnt   (settle_cnt)
  );

  lpif_sat_counter #(.W(CNT_W)) u_tmo_cnt (
    .clk   (clk_wr),
    .rst_n (rst_wr_n),
    .clr   (tmo_clr),
    .inc   (tmo_inc),
    .cnt   (tmo_cnt)
  );

  lpif_sat_counter #(.W(ERRCNT_W)) u_err_cnt (
    .clk   (clk_wr),
    .rst_n (rst_wr_n),
    .clr   (1'b0),
    .inc   (err_entry),
    .cnt   (err_count)
  );

endmodule

// File: tb/tb_lpif_link_bringup_ctrl.sv
// Self-checking bench for lpif_link_bringup_ctrl: vector table, directed corner sequences,
// and randomized traffic against a phase-level reference model.
module tb_lpif_link_bringup_ctrl;

  localparam int CNT_W    = 16;
  localparam int ERRCNT_W = 8;

  logic                clk_wr = 1'b0;
  logic                rst_wr_n;
  logic                link_en, phy_ready, rx_align_done, dstrm_valid, err_clr;
  logic [3:0]          dstrm_state;
  logic [CNT_W-1:0]    settle_value, timeout_value;
  logic                tx_online, rx_online, link_up, link_err;
  logic [ERRCNT_W-1:0] err_count;
  logic [2:0]          fsm_state;

  int checks = 0;
  int errors = 0;

  always #5 clk_wr = ~clk_wr;

  lpif_link_bringup_ctrl #(
    .CNT_W        (CNT_W),
    .ACTIVE_STATE (4'h1),
    .ERRCNT_W     (ERRCNT_W)
  ) dut (
    .clk_wr        (clk_wr),
    .rst_wr_n      (rst_wr_n),
    .link_en       (link_en),
    .phy_ready     (phy_ready),
    .rx_align_done (rx_align_done),
    .dstrm_valid   (dstrm_valid),
    .dstrm_state   (dstrm_state),
    .settle_value  (settle_value),
    .timeout_value (timeout_value),
    .err_clr       (err_clr),
    .tx_online     (tx_online),
    .rx_online     (rx_online),
    .link_up       (link_up),
    .link_err      (link_err),
    .err_count     (err_count),
    .fsm_state     (fsm_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase number (0..5 as published), visit-local counts, total errors.
  int m_ph, m_settle, m_tmo, m_errs;

  task automatic model_reset();
    m_ph = 0; m_settle = 0; m_tmo = 0; m_errs = 0;
  endtask

  task automatic model_step();
    int nxt;
    nxt = m_ph;
    if (m_ph == 5) begin
      if (err_clr) nxt = 0;
    end else if (m_ph == 0) begin
      if (link_en) nxt = 1;
    end else if (!link_en) nxt = 0;
    else if (m_ph >= 2 && !phy_ready) nxt = 5;
    else if ((m_ph == 2 || m_ph == 3) && timeout_value != 0 && m_tmo >= int'(timeout_value)) nxt = 5;
    else if (m_ph == 1 && phy_ready && m_settle == int'(settle_value)) nxt = 2;
    else if (m_ph == 2 && rx_align_done) nxt = 3;
    else if (m_ph == 3 && dstrm_valid && dstrm_state == 4'h1) nxt = 4;
    else if (m_ph == 4 && !rx_align_done) nxt = 5;

    m_settle = (m_ph == 1 && nxt == 1 && phy_ready) ? ((m_settle < 65535) ? m_settle + 1 : 65535) : 0;
    m_tmo    = (nxt == m_ph && (m_ph == 2 || m_ph == 3)) ? ((m_tmo < 65535) ? m_tmo + 1 : 65535) : 0;
    if (nxt == 5 && m_ph != 5 && m_errs < 255) m_errs++;
    m_ph = nxt;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_tx"},    32'(tx_online), 32'(m_ph >= 2 && m_ph <= 4));
    chk({tag, "_rx"},    32'(rx_online), 32'(m_ph == 3 || m_ph == 4));
    chk({tag, "_up"},    32'(link_up),   32'(m_ph == 4));
    chk({tag, "_err"},   32'(link_err),  32'(m_ph == 5));
    chk({tag, "_cnt"},   32'(err_count), 32'(m_errs));
    chk({tag, "_state"}, 32'(fsm_state), 32'(m_ph));
  endtask

  // Inputs are driven at posedge+1; the model consumes them, then outputs are sampled at the next posedge+1.
  task automatic step();
    model_step();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic idle_inputs();
    link_en = 0; phy_ready = 0; rx_align_done = 0; dstrm_valid = 0; dstrm_state = 4'h0; err_clr = 0;
  endtask

  task automatic do_reset();
    rst_wr_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk_wr);
    #1;
    rst_wr_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] ctl;   // link_en, phy_ready, rx_align_done, dstrm_valid
    logic [3:0] ds;
    logic       ec;
    logic [3:0] ex;    // tx_online, rx_online, link_up, link_err
    logic [2:0] st;
    logic [7:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ctl, input logic [3:0] ds, input logic ec,
                              input logic [3:0] ex, input logic [2:0] st, input logic [7:0] cnt);
    vec_t v;
    v.ctl = ctl; v.ds = ds; v.ec = ec; v.ex = ex; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    settle_value = '0;
    timeout_value = '0;
    do_reset();

    vecs[0]  = mk(4'b0000, 4'h0, 1'b0, 4'b0000, 3'd0, 8'd0);
    vecs[1]  = mk(4'b1000, 4'h0, 1'b0, 4'b0000, 3'd1, 8'd0);
    vecs[2]  = mk(4'b1000, 4'h0, 1'b0, 4'b0000, 3'd1, 8'd0);
    vecs[3]  = mk(4'b1100, 4'h0, 1'b0, 4'b1000, 3'd2, 8'd0);
    vecs[4]  = mk(4'b1100, 4'h0, 1'b0, 4'b1000, 3'd2, 8'd0);
    vecs[5]  = mk(4'b1110, 4'h0, 1'b0, 4'b1100, 3'd3, 8'd0);
    vecs[6]  = mk(4'b1111, 4'h2, 1'b0, 4'b1100, 3'd3, 8'd0);
    vecs[7]  = mk(4'b1110, 4'h1, 1'b0, 4'b1100, 3'd3, 8'd0);
    vecs[8]  = mk(4'b1111, 4'h1, 1'b0, 4'b1110, 3'd4, 8'd0);
    vecs[9]  = mk(4'b1110, 4'h0, 1'b1, 4'b1110, 3'd4, 8'd0);
    vecs[10] = mk(4'b1100, 4'h0, 1'b0, 4'b0001, 3'd5, 8'd1);
    vecs[11] = mk(4'b0000, 4'h0, 1'b0, 4'b0001, 3'd5, 8'd1);
    vecs[12] = mk(4'b0000, 4'h0, 1'b1, 4'b0000, 3'd0, 8'd1);
    vecs[13] = mk(4'b1100, 4'h0, 1'b0, 4'b0000, 3'd1, 8'd1);
    vecs[14] = mk(4'b1100, 4'h0, 1'b0, 4'b1000, 3'd2, 8'd1);
    vecs[15] = mk(4'b1000, 4'h0, 1'b0, 4'b0001, 3'd5, 8'd2);
    vecs[16] = mk(4'b1100, 4'h0, 1'b1, 4'b0000, 3'd0, 8'd2);
    vecs[17] = mk(4'b1100, 4'h0, 1'b0, 4'b0000, 3'd1, 8'd2);
    vecs[18] = mk(4'b1100, 4'h0, 1'b0, 4'b1000, 3'd2, 8'd2);
    vecs[19] = mk(4'b0000, 4'h0, 1'b0, 4'b0000, 3'd0, 8'd2);

    // Reset state
    chk("reset_tx",    32'(tx_online), 32'd0);
    chk("reset_rx",    32'(rx_online), 32'd0);
    chk("reset_up",    32'(link_up),   32'd0);
    chk("reset_err",   32'(link_err),  32'd0);
    chk("reset_cnt",   32'(err_count), 32'd0);
    chk("reset_state", 32'(fsm_state), 32'd0);

    // Vector table, settle=0, timeouts disabled
    for (int i = 0; i < 20; i++) begin
      {link_en, phy_ready, rx_align_done, dstrm_valid} = vecs[i].ctl;
      dstrm_state = vecs[i].ds;
      err_clr     = vecs[i].ec;
      step();
      chk($sformatf("vec%0d_onl", i),   32'({tx_online, rx_online, link_up, link_err}), 32'(vecs[i].ex));
      chk($sformatf("vec%0d_state", i), 32'(fsm_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_cnt", i),   32'(err_count), 32'(vecs[i].cnt));
    end

    // Normal bring-up with settle=4, then simultaneous link_en/phy_ready drop in ACTIVE
    do_reset();
    settle_value = 16'd4;
    link_en = 1; phy_ready = 1;
    n = 0;
    while (!tx_online && n < 20) begin step(); n++; end
    chk("bringup_tx_latency", 32'(n), 32'd6);
    chk("bringup_tx_state",   32'(fsm_state), 32'd2);
    rx_align_done = 1;
    step();
    chk("bringup_rx_online", 32'(rx_online), 32'd1);
    chk("bringup_rx_state",  32'(fsm_state), 32'd3);
    dstrm_valid = 1; dstrm_state = 4'h1;
    step();
    chk("bringup_link_up", 32'(link_up),   32'd1);
    chk("bringup_active",  32'(fsm_state), 32'd4);
    link_en = 0; phy_ready = 0;
    step();
    chk("teardown_state", 32'(fsm_state), 32'd0);
    chk("teardown_err",   32'(link_err),  32'd0);
    chk("teardown_onl",   32'({tx_online, rx_online, link_up}), 32'd0);
    chk("teardown_cnt",   32'(err_count), 32'd0);

    // Settle glitch after three good cycles
    do_reset();
    settle_value = 16'd4;
    link_en = 1; phy_ready = 1;
    step();
    repeat (3) step();
    phy_ready = 0;
    step();
    chk("glitch_tx_low", 32'(tx_online), 32'd0);
    phy_ready = 1;
    n = 0;
    while (!tx_online && n < 20) begin step(); n++; end
    chk("glitch_tx_latency", 32'(n), 32'd5);

    // Phase timeout in TX_ON
    do_reset();
    settle_value = 16'd0;
    timeout_value = 16'd10;
    link_en = 1; phy_ready = 1;
    step();
    step();
    chk("tmo_in_tx", 32'(fsm_state), 32'd2);
    n = 0;
    while (fsm_state != 3'd5 && n < 40) begin step(); n++; end
    chk("tmo_cycles",   32'(n),         32'd11);
    chk("tmo_link_err", 32'(link_err),  32'd1);
    chk("tmo_err_cnt",  32'(err_count), 32'd1);
    chk("tmo_tx_off",   32'(tx_online), 32'd0);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("tmo_clr_state", 32'(fsm_state), 32'd0);
    chk("tmo_clr_err",   32'(link_err),  32'd0);
    timeout_value = 16'd0;

    // Error counter saturation via repeated PHY loss in TX_ON
    do_reset();
    for (int i = 0; i < 260; i++) begin
      link_en = 1; phy_ready = 1; err_clr = 0;
      step();
      step();
      phy_ready = 0;
      step();
      chk($sformatf("sat_cnt_%0d", i), 32'(err_count), (i < 255) ? 32'(i + 1) : 32'd255);
      err_clr = 1;
      step();
    end
    err_clr = 0;

    // Asynchronous reset while ACTIVE
    link_en = 1; phy_ready = 1; rx_align_done = 1; dstrm_valid = 1; dstrm_state = 4'h1;
    repeat (4) step();
    chk("arst_pre_active", 32'(fsm_state), 32'd4);
    #2;
    rst_wr_n = 1'b0;
    #1;
    chk("arst_onl",   32'({tx_online, rx_online, link_up, link_err}), 32'd0);
    chk("arst_cnt",   32'(err_count), 32'd0);
    chk("arst_state", 32'(fsm_state), 32'd0);
    idle_inputs();
    model_reset();
    @(posedge clk_wr);
    #1;
    rst_wr_n = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        settle_value  = 16'($urandom_range(0, 5));
        timeout_value = 16'($urandom_range(0, 12));
      end
      link_en       = ($urandom_range(0, 99) < 95);
      phy_ready     = ($urandom_range(0, 99) < 90);
      rx_align_done = ($urandom_range(0, 99) < 75);
      dstrm_valid   = ($urandom_range(0, 99) < 50);
      dstrm_state   = ($urandom_range(0, 1) != 0) ? 4'h1 : 4'($urandom_range(0, 15));
      err_clr       = ($urandom_range(0, 99) < 20);
      step();
      compare_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
